// File: rtl/compare_ctrl.sv
// compare_ctrl: sequencer for the dual-register equality comparator.
// It accepts operand pairs on a valid/ready request channel and loads both
// comparator registers. Once the registers have settled it samples the equal
// flag and returns it on a valid/ready response channel. It also keeps
// saturating match/mismatch statistics.
module compare_ctrl #(
    parameter int unsigned D  = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    // request channel
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [D-1:0]  req_a,
    input  logic [D-1:0]  req_b,
    // statistics control
    input  logic          stat_clr,
    // comparator interface
    output logic [D-1:0]  cmp_data1,
    output logic [D-1:0]  cmp_data2,
    output logic          cmp_select1,
    output logic          cmp_select2,
    output logic          cmp_clr,
    input  logic          cmp_eq,
    // response channel
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_match,
    // statistics / status
    output logic [CW-1:0] match_cnt,
    output logic [CW-1:0] mismatch_cnt,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RESP,
        CLEAR
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         req_hs;
    logic         resp_hs;
    logic [D-1:0] op_a;
    logic [D-1:0] op_b;

    // The register parks in CLEAR while reset is high, so the one CLEAR cycle
    // follows release without an extra flag. The decode below masks this with
    // the IDLE-like reset values for as long as reset stays asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        cmp_select1 = 1'b0;
        cmp_select2 = 1'b0;
        cmp_clr     = 1'b0;
        resp_valid  = 1'b0;
        busy        = 1'b1;
        req_hs      = 1'b0;
        resp_hs     = 1'b0;
        if (reset) begin
            req_ready = 1'b1;
            cmp_clr   = 1'b1;
            busy      = 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cmp_clr   = 1'b1;
                    state_nxt = IDLE;
                end
                IDLE: begin
                    busy      = 1'b0;
                    req_ready = 1'b1;
                    if (req_valid) begin
                        req_hs    = 1'b1;
                        state_nxt = LOAD;
                    end
                end
                LOAD: begin
                    cmp_select1 = 1'b1;
                    cmp_select2 = 1'b1;
                    state_nxt   = SETTLE;
                end
                SETTLE: begin
                    state_nxt = RESP;
                end
                RESP: begin
                    resp_valid = 1'b1;
                    if (resp_ready) begin
                        resp_hs   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = CLEAR;
                end
            endcase
        end
    end

    // Operand latch on request handshake. The latched operands also drive the
    // comparator data buses: they only change on the edge entering LOAD, so
    // the buses hold their last loaded values everywhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a <= '0;
            op_b <= '0;
        end else if (req_hs) begin
            op_a <= req_a;
            op_b <= req_b;
        end
    end

    assign cmp_data1 = op_a;
    assign cmp_data2 = op_b;

    // Sample the comparator result on the edge leaving SETTLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_match <= 1'b0;
        end else if (state == SETTLE) begin
            resp_match <= cmp_eq;
        end
    end

    // Saturating statistics; a clear takes priority over a counted response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
        end else if (stat_clr) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
        end else if (resp_hs) begin
            if (resp_match) begin
                if (match_cnt != '1) begin
                    match_cnt <= match_cnt + CW'(1);
                end
            end else begin
                if (mismatch_cnt != '1) begin
                    mismatch_cnt <= mismatch_cnt + CW'(1);
                end
            end
        end
    end

endmodule
